// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: word-addressed data RAM
// with a combinational read, registered write-back triple and sticky error flag.
module mem_wb_stage #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        ex_wb_en,
  input  logic        ex_mem_r_en,
  input  logic        ex_mem_w_en,
  input  logic [3:0]  ex_dst,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_st_val,
  output logic        wb_en,
  output logic [3:0]  wb_dst,
  output logic [31:0] wb_value,
  output logic        addr_err
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0]      mem_q [MEM_WORDS];
  logic [31:0]      off;
  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             mem_we;
  logic             dual_access;
  logic             access_err;
  logic [31:0]      rd_data;
  logic [31:0]      sel_value;

  logic        wb_en_q,    wb_en_d;
  logic [3:0]  wb_dst_q,   wb_dst_d;
  logic [31:0] wb_value_q, wb_value_d;
  logic        addr_err_q, addr_err_d;

  // Subtracting the base makes addresses below it wrap high, so one compare covers both ends.
  assign off    = ex_alu_res - BASE_ADDR;
  assign legal  = (off < MEM_BYTES) && (off[1:0] == 2'b00);
  assign idx    = off[IDX_W+1:2];

  assign dual_access = ex_mem_w_en & ex_mem_r_en;
  assign access_err  = dual_access | ((ex_mem_w_en | ex_mem_r_en) & ~legal);
  assign mem_we      = ex_mem_w_en & legal & ~freeze;

  assign rd_data   = legal ? mem_q[idx] : 32'h0;
  assign sel_value = (ex_mem_r_en & ~ex_mem_w_en) ? rd_data : ex_alu_res;

  // Whole-array clear on reset keeps the RAM in flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= ex_st_val;
    end
  end

  always_comb begin
    wb_en_d    = wb_en_q;
    wb_dst_d   = wb_dst_q;
    wb_value_d = wb_value_q;
    addr_err_d = addr_err_q;
    if (!freeze) begin
      wb_en_d    = ex_wb_en & (ex_dst != 4'hF);
      wb_dst_d   = ex_dst;
      wb_value_d = sel_value;
      if (access_err) begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      wb_dst_q   <= 4'h0;
      wb_value_q <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      wb_en_q    <= wb_en_d;
      wb_dst_q   <= wb_dst_d;
      wb_value_q <= wb_value_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_dst   = wb_dst_q;
  assign wb_value = wb_value_q;
  assign addr_err = addr_err_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the ARM pipeline. It takes EX/MEM results, performs data-memory stores and loads against an internal word-addressed RAM, and produces the registered write-back triple (wb_en, wb_dst, wb_value). The register file consumes this triple and writes it on the following negative clock edge. It also raises a sticky error flag on illegal memory accesses.

## Interface
- MEM_WORDS, 64: data memory depth in 32-bit words.
- BASE_ADDR, 1024: byte address mapped to word 0.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- freeze  in  1  stall. Holds the MEM/WB register and suppresses memory writes.
- ex_wb_en  in  1  instruction writes a register.
- ex_mem_r_en  in  1  load (LDR).
- ex_mem_w_en  in  1  store (STR).
- ex_dst  in  4  destination register index.
- ex_alu_res  in  32  ALU result; this is the byte address for loads and stores.
- ex_st_val  in  32  store data (value of Rd).
- wb_en  out  1  registered write enable to the register file.
- wb_dst  out  4  registered destination index.
- wb_value  out  32  registered write-back data.
- addr_err  out  1  sticky illegal-access flag.

## Operation
- Address decode: off = ex_alu_res - BASE_ADDR, 32-bit unsigned with wrap.
  - Legal iff off < MEM_WORDS*4 and off[1:0] == 0.
  - Word index = off[31:2].
  - Addresses below BASE_ADDR wrap to large values and are therefore illegal.
- Store: ex_mem_w_en=1, legal address, freeze=0 → mem[idx] <= ex_st_val at the rising edge.
- Store with an illegal address: memory is unchanged and addr_err is set.
- Load: ex_mem_r_en=1 reads mem[idx] combinationally.
  - Illegal address: the read data is 32'h0 and addr_err is set.
- ex_mem_w_en=1 and ex_mem_r_en=1 together: the store is performed and the read is ignored. Write-back data is the ALU result. addr_err is set, whatever the address.
- Write-back mux: the selected value is the memory data when ex_mem_r_en=1 and ex_mem_w_en=0; otherwise it is ex_alu_res.
- MEM/WB register, updated on each rising edge with freeze=0:
  - wb_en <= ex_wb_en & (ex_dst != 4'hF)
  - wb_dst <= ex_dst
  - wb_value <= selected value
- R15 writes are always dropped (wb_en forced 0), because the register file holds R0–R14 only.
- freeze=1: the MEM/WB register holds its value, no memory write occurs, and addr_err does not update.
- addr_err stays at 1 until rst.

## Timing
- Reset values: wb_en=0, wb_dst=0, wb_value=0, addr_err=0.
- Reset also clears every memory word to 0, taking one cycle.
- rst has priority over freeze and over any store.
- Reset asserted mid-stream cancels any store presented in that cycle.
- Latency: EX/MEM inputs in cycle N appear on wb_* after rising edge N. The register file commits them at the negedge inside cycle N+1.
- Store in cycle N followed by a load from the same address in cycle N+1: the load returns the new data. No bypass is needed, because the write lands at edge N.
- Back-to-back stores to the same address: the last one wins.
- No handshake beyond freeze. The upstream stage holds its inputs stable while freeze=1.
- Freeze releasing at edge N: the inputs present in cycle N are captured normally.

## Test plan
- Reset: drive rst=1 for 1 cycle with ex_mem_w_en=1 → all wb_* = 0, addr_err=0, mem[0..63] read back as 0.
- Store/load: STR 0xDEADBEEF to 1028, then LDR from 1028 with ex_dst=3, ex_wb_en=1 → the next cycle shows wb_en=1, wb_dst=3, wb_value=0xDEADBEEF.
- ALU passthrough: ex_alu_res=0x12345678, ex_dst=5, no memory access → wb_value=0x12345678, wb_en=1, wb_dst=5.
- Illegal accesses (each case → memory unchanged, addr_err=1 and held until rst):
  - store to 1020 (below base);
  - store to 1026 (misaligned);
  - load from 1280 → wb_value=0.
- Freeze: capture value A, then hold freeze=1 for 3 cycles while presenting value B plus a store → wb_* stays at A and memory is unchanged. Release freeze → B is captured.
- R15 and dual-enable:
  - ex_dst=15 with ex_wb_en=1 → wb_en=0.
  - ex_mem_r_en=ex_mem_w_en=1 at 1032 → the store is performed, wb_value=1032, addr_err=1.
